mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch and a data requester,
// with a per-transaction ack timeout. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              a_i_f_syn,
  input  logic [AWIDTH-1:0] a_i_f_addr,
  output logic              a_o_f_ack,
  output logic              a_o_f_err,
  output logic [DWIDTH-1:0] a_o_f_rdata,
  input  logic              a_i_d_syn,
  input  logic              a_i_d_we,
  input  logic [AWIDTH-1:0] a_i_d_addr,
  input  logic [DWIDTH-1:0] a_i_d_wdata,
  output logic              a_o_d_ack,
  output logic              a_o_d_err,
  output logic [DWIDTH-1:0] a_o_d_rdata,
  output logic              a_o_m_syn,
  output logic              a_o_m_we,
  output logic [AWIDTH-1:0] a_o_m_addr,
  output logic [DWIDTH-1:0] a_o_m_wdata,
  input  logic              a_i_m_ack,
  input  logic [DWIDTH-1:0] a_i_m_rdata,
  output logic              a_o_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_F = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              lastGrantD_q, lastGrantD_d;
  logic [CW-1:0]     waitCnt_q, waitCnt_d;
  logic              mSyn_q, mSyn_d;
  logic              mWe_q, mWe_d;
  logic [AWIDTH-1:0] mAddr_q, mAddr_d;
  logic [DWIDTH-1:0] mWdata_q, mWdata_d;
  logic              fAck_q, fAck_d;
  logic              fErr_q, fErr_d;
  logic [DWIDTH-1:0] fRdata_q, fRdata_d;
  logic              dAck_q, dAck_d;
  logic              dErr_q, dErr_d;
  logic [DWIDTH-1:0] dRdata_q, dRdata_d;
  logic              busy_q, busy_d;
  logic              fElig, dElig;

  // A requester whose completion pulse is visible this cycle is still holding
  // syn for that cycle only, so it must not be re-granted.
  assign fElig = a_i_f_syn & ~fAck_q & ~fErr_q;
  assign dElig = a_i_d_syn & ~dAck_q & ~dErr_q;

  always_comb begin
    state_d      = state_q;
    lastGrantD_d = lastGrantD_q;
    waitCnt_d    = waitCnt_q;
    mSyn_d       = mSyn_q;
    mWe_d        = mWe_q;
    mAddr_d      = mAddr_q;
    mWdata_d     = mWdata_q;
    fAck_d       = 1'b0;
    fErr_d       = 1'b0;
    fRdata_d     = fRdata_q;
    dAck_d       = 1'b0;
    dErr_d       = 1'b0;
    dRdata_d     = dRdata_q;

    unique case (state_q)
      IDLE: begin
        if (fElig && (!dElig || lastGrantD_q)) begin
          state_d      = GRANT_F;
          mAddr_d      = a_i_f_addr;
          mWe_d        = 1'b0;
          mSyn_d       = 1'b1;
          lastGrantD_d = 1'b0;
          waitCnt_d    = '0;
        end else if (dElig) begin
          state_d      = GRANT_D;
          mAddr_d      = a_i_d_addr;
          mWe_d        = a_i_d_we;
          mWdata_d     = a_i_d_wdata;
          mSyn_d       = 1'b1;
          lastGrantD_d = 1'b1;
          waitCnt_d    = '0;
        end
      end
      GRANT_F, GRANT_D: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (a_i_m_ack) begin
          state_d = IDLE;
          mSyn_d  = 1'b0;
          if (state_q == GRANT_F) begin
            fAck_d   = 1'b1;
            fRdata_d = a_i_m_rdata;
          end else begin
            dAck_d   = 1'b1;
            dRdata_d = a_i_m_rdata;
          end
        end else if (waitCnt_q == CntLast) begin
          state_d = IDLE;
          mSyn_d  = 1'b0;
          if (state_q == GRANT_F) fErr_d = 1'b1;
          else                    dErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mSyn_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q      <= IDLE;
      lastGrantD_q <= 1'b1;
      waitCnt_q    <= '0;
      mSyn_q       <= 1'b0;
      mWe_q        <= 1'b0;
      mAddr_q      <= '0;
      mWdata_q     <= '0;
      fAck_q       <= 1'b0;
      fErr_q       <= 1'b0;
      fRdata_q     <= '0;
      dAck_q       <= 1'b0;
      dErr_q       <= 1'b0;
      dRdata_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastGrantD_q <= lastGrantD_d;
      waitCnt_q    <= waitCnt_d;
      mSyn_q       <= mSyn_d;
      mWe_q        <= mWe_d;
      mAddr_q      <= mAddr_d;
      mWdata_q     <= mWdata_d;
      fAck_q       <= fAck_d;
      fErr_q       <= fErr_d;
      fRdata_q     <= fRdata_d;
      dAck_q       <= dAck_d;
      dErr_q       <= dErr_d;
      dRdata_q     <= dRdata_d;
      busy_q       <= busy_d;
    end
  end

  assign a_o_f_ack   = fAck_q;
  assign a_o_f_err   = fErr_q;
  assign a_o_f_rdata = fRdata_q;
  assign a_o_d_ack   = dAck_q;
  assign a_o_d_err   = dErr_q;
  assign a_o_d_rdata = dRdata_q;
  assign a_o_m_syn   = mSyn_q;
  assign a_o_m_we    = mWe_q;
  assign a_o_m_addr  = mAddr_q;
  assign a_o_m_wdata = mWdata_q;
  assign a_o_busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter: directed cases plus randomized transactions
// checked against a transaction-level model of grant order, latency and timeout.
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fSyn = 1'b0;
  logic [31:0] fAddr = '0;
  logic        dSyn = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic        mAck = 1'b0;
  logic [31:0] mRdata = '0;
  logic        fAck, fErr, dAck, dErr, mSyn, mWe, busy;
  logic [31:0] fRdata, dRdata, mAddr, mWdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] expF = '0;
  logic [31:0] expD = '0;
  bit lastGrantD = 1'b1;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO)) dut (
    .a_clk(clk), .a_rst(rst),
    .a_i_f_syn(fSyn), .a_i_f_addr(fAddr),
    .a_o_f_ack(fAck), .a_o_f_err(fErr), .a_o_f_rdata(fRdata),
    .a_i_d_syn(dSyn), .a_i_d_we(dWe), .a_i_d_addr(dAddr), .a_i_d_wdata(dWdata),
    .a_o_d_ack(dAck), .a_o_d_err(dErr), .a_o_d_rdata(dRdata),
    .a_o_m_syn(mSyn), .a_o_m_we(mWe), .a_o_m_addr(mAddr), .a_o_m_wdata(mWdata),
    .a_i_m_ack(mAck), .a_i_m_rdata(mRdata),
    .a_o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fAck, fErr, dAck, dErr, mSyn, mWe, busy} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0", {fAck, fErr, dAck, dErr, mSyn, mWe, busy});
    end
    checks++;
    if ({mAddr, mWdata, fRdata, dRdata} !== 128'b0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0", {mAddr, mWdata, fRdata, dRdata});
    end
    rst = 1'b0;
    expF = '0; expD = '0; lastGrantD = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_fetch();
    fSyn = 1'b1; fAddr = 32'h4;
    @(posedge clk); #1;
    checks++;
    if ({mSyn, mWe, busy, mAddr} !== {3'b101, 32'h4}) begin
      errors++; $display("[TB] FAIL fetch_grant: got %b/%h expected 101/4", {mSyn, mWe, busy}, mAddr);
    end
    @(posedge clk); #1;
    mAck = 1'b1; mRdata = 32'h2008_0005;
    @(posedge clk); #1;
    mAck = 1'b0; fSyn = 1'b0; mRdata = 32'hFFFF_FFFF;
    checks++;
    if ({fAck, fErr, dAck, mSyn, fRdata} !== {4'b1000, 32'h2008_0005}) begin
      errors++; $display("[TB] FAIL fetch_ack: got %b/%h expected 1000/20080005", {fAck, fErr, dAck, mSyn}, fRdata);
    end
    expF = 32'h2008_0005; lastGrantD = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({fAck, busy, mSyn, fRdata, mAddr} !== {3'b000, 32'h2008_0005, 32'h4}) begin
      errors++; $display("[TB] FAIL fetch_after: got %b/%h/%h expected 000/20080005/4", {fAck, busy, mSyn}, fRdata, mAddr);
    end
  endtask

  task automatic test_data_write();
    dSyn = 1'b1; dWe = 1'b1; dAddr = 32'h10; dWdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++;
    if ({mSyn, mWe, mAddr, mWdata} !== {2'b11, 32'h10, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL write_grant: got %b/%h/%h expected 11/10/deadbeef", {mSyn, mWe}, mAddr, mWdata);
    end
    mAck = 1'b1; mRdata = 32'h1234_5678;
    @(posedge clk); #1;
    mAck = 1'b0; dSyn = 1'b0; dWe = 1'b0;
    checks++;
    if ({dAck, dErr, fAck, fErr, fRdata, dRdata} !== {4'b1000, expF, 32'h1234_5678}) begin
      errors++; $display("[TB] FAIL write_ack: got %b/%h/%h expected 1000/%h/12345678", {dAck, dErr, fAck, fErr}, fRdata, dRdata, expF);
    end
    expD = 32'h1234_5678; lastGrantD = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dAck, busy, mWe, mAddr} !== {3'b001, 32'h10}) begin
      errors++; $display("[TB] FAIL write_hold: got %b/%h expected 001/10", {dAck, busy, mWe}, mAddr);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit sawAck = 1'b0;
    bit done = 1'b0;
    fSyn = 1'b1; fAddr = 32'h88;
    for (int w = 0; w < 40 && !done; w++) begin
      @(posedge clk); #1;
      if (fAck) sawAck = 1'b1;
      if (fErr) done = 1'b1;
      else if (mSyn) cnt++;
    end
    fSyn = 1'b0;
    checks++;
    if ({done, sawAck, mSyn, busy} !== 4'b1000 || cnt != TO) begin
      errors++; $display("[TB] FAIL timeout_f: got err=%b ack=%b syn=%b busy=%b cycles=%0d expected 1000 cycles=%0d", done, sawAck, mSyn, busy, cnt, TO);
    end
    @(posedge clk); #1;
    checks++;
    if ({fErr, fAck, busy, fRdata} !== {3'b000, expF}) begin
      errors++; $display("[TB] FAIL timeout_after: got %b/%h expected 000/%h", {fErr, fAck, busy}, fRdata, expF);
    end
    lastGrantD = 1'b0;
    cnt = 0; done = 1'b0;
    dSyn = 1'b1; dWe = 1'b0; dAddr = 32'h44;
    for (int w = 0; w < 40 && !done; w++) begin
      @(posedge clk); #1;
      if (dAck || dErr) done = 1'b1;
      else if (mSyn) begin
        cnt++;
        if (cnt == TO) begin mAck = 1'b1; mRdata = 32'hCAFE_0001; end
      end
    end
    mAck = 1'b0; dSyn = 1'b0;
    checks++;
    if ({dAck, dErr, dRdata} !== {2'b10, 32'hCAFE_0001}) begin
      errors++; $display("[TB] FAIL timeout_ack_wins: got %b/%h expected 10/cafe0001", {dAck, dErr}, dRdata);
    end
    expD = 32'hCAFE_0001; lastGrantD = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 8; i++) begin
      mAck = 1'($urandom_range(0, 1)); mRdata = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({fAck, fErr, dAck, dErr, busy, mSyn} !== 6'b0 || fRdata !== expF || dRdata !== expD) begin
        errors++; $display("[TB] FAIL idle_ack: got %b/%h/%h expected 0/%h/%h", {fAck, fErr, dAck, dErr, busy, mSyn}, fRdata, dRdata, expF, expD);
      end
    end
    mAck = 1'b0;
  endtask

  task automatic test_round_robin();
    bit order[$];
    bit prevAck = 1'b0;
    rst = 1'b1;
    fSyn = 1'b1; fAddr = 32'h100; dSyn = 1'b1; dWe = 1'b0; dAddr = 32'h200;
    @(posedge clk); #3;
    rst = 1'b0;
    expF = '0; expD = '0;
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if ({mSyn, mAddr} !== {1'b1, 32'h100}) begin
          errors++; $display("[TB] FAIL rr_first_grant: got %b/%h expected 1/100", mSyn, mAddr);
        end
      end
      if (fAck && dAck) begin
        checks++; errors++; $display("[TB] FAIL rr_dual_ack: got both acks expected one");
      end
      if (prevAck) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("[TB] FAIL rr_gap: got busy %b expected 1", busy);
        end
      end
      prevAck = fAck | dAck;
      if (prevAck) begin
        order.push_back(dAck);
        checks++;
        if ({busy, mSyn} !== 2'b00) begin
          errors++; $display("[TB] FAIL rr_ack_idle: got %b expected 00", {busy, mSyn});
        end
      end
      mAck = mSyn;
    end
    fSyn = 1'b0; dSyn = 1'b0; mAck = 1'b0;
    lastGrantD = 1'b1;
    checks++;
    if (order.size() != 4) begin
      errors++; $display("[TB] FAIL rr_count: got %0d acks expected 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != 1'(i % 2)) begin
          errors++; $display("[TB] FAIL rr_order: got %0d at slot %0d expected %0d", order[i], i, i % 2);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    dSyn = 1'b1; dWe = 1'b1; dAddr = 32'h20; dWdata = $urandom;
    @(posedge clk); #1;
    checks++;
    if (mSyn !== 1'b1) begin
      errors++; $display("[TB] FAIL rmid_grant: got %b expected 1", mSyn);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mSyn, busy, fAck, dAck, mWe} !== 5'b0) begin
      errors++; $display("[TB] FAIL rmid_async: got %b expected 0", {mSyn, busy, fAck, dAck, mWe});
    end
    mAck = 1'b1; mRdata = 32'h5A5A_5A5A; dSyn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expF = '0; expD = '0; lastGrantD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fAck, fErr, dAck, dErr, busy} !== 5'b0 || dRdata !== 32'h0) begin
        errors++; $display("[TB] FAIL rmid_stale: got %b/%h expected 0/0", {fAck, fErr, dAck, dErr, busy}, dRdata);
      end
    end
    mAck = 1'b0;
  endtask

  task automatic test_random();
    int mode, n, cyc;
    int lat[2];
    logic [31:0] rd[2];
    logic [31:0] fa, da, dw;
    bit we, first, who, found, done, dropMid, expAck, gotAck, gotErr;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      fa = $urandom; da = fa ^ 32'h1; dw = $urandom; we = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        lat[k] = $urandom_range(1, TO + 2);
        rd[k] = $urandom;
      end
      dropMid = (mode != 2) && ($urandom_range(0, 1) == 1);
      n = (mode == 2) ? 2 : 1;
      first = (mode == 2) ? !lastGrantD : (mode == 1);
      fSyn = (mode != 1); fAddr = fa;
      dSyn = (mode != 0); dAddr = da; dWe = we; dWdata = dw;
      for (int k = 0; k < n; k++) begin
        who = (k == 0) ? first : !first;
        found = 1'b0;
        for (int w = 0; w < 4 && !found; w++) begin
          @(posedge clk); #1;
          checks++;
          if ({fAck, fErr, dAck, dErr} !== 4'b0) begin
            errors++; $display("[TB] FAIL rnd_pulse_len: got %b expected 0", {fAck, fErr, dAck, dErr});
          end
          if (mSyn) found = 1'b1;
        end
        checks++;
        if (!found) begin
          errors++; $display("[TB] FAIL rnd_grant_wait: got no m_syn expected grant of %0d", who);
          continue;
        end
        checks++;
        if (mAddr !== (who ? da : fa) || mWe !== (who ? we : 1'b0) || (who && mWdata !== dw)) begin
          errors++; $display("[TB] FAIL rnd_grant: got %h/%b/%h expected requester %0d", mAddr, mWe, mWdata, who);
        end
        lastGrantD = who;
        if (dropMid) begin
          if (who) dSyn = 1'b0; else fSyn = 1'b0;
        end
        cyc = 1;
        if (lat[k] == 1) begin mAck = 1'b1; mRdata = rd[k]; end
        done = 1'b0;
        for (int w = 0; w < TO + 3 && !done; w++) begin
          @(posedge clk); #1;
          checks++;
          if (who ? (fAck | fErr) : (dAck | dErr)) begin
            errors++; $display("[TB] FAIL rnd_other_pulse: got pulse on requester %0d expected none", !who);
          end
          if (who ? (dAck | dErr) : (fAck | fErr)) done = 1'b1;
          else begin
            cyc++;
            if (cyc >= lat[k]) begin mAck = 1'b1; mRdata = rd[k]; end
          end
        end
        mAck = 1'b0; mRdata = $urandom;
        gotAck = who ? dAck : fAck;
        gotErr = who ? dErr : fErr;
        expAck = (lat[k] <= TO);
        checks++;
        if ({gotAck, gotErr, mSyn} !== {expAck, !expAck, 1'b0} || cyc != (expAck ? lat[k] : TO)) begin
          errors++; $display("[TB] FAIL rnd_complete: got ack=%b err=%b syn=%b cycles=%0d expected ack=%b lat=%0d", gotAck, gotErr, mSyn, cyc, expAck, lat[k]);
        end
        if (expAck) begin
          if (who) expD = rd[k]; else expF = rd[k];
        end
        checks++;
        if (fRdata !== expF || dRdata !== expD) begin
          errors++; $display("[TB] FAIL rnd_rdata: got %h/%h expected %h/%h", fRdata, dRdata, expF, expD);
        end
        if (who) dSyn = 1'b0; else fSyn = 1'b0;
      end
      fSyn = 1'b0; dSyn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({fAck, fErr, dAck, dErr, busy, mSyn} !== 6'b0) begin
        errors++; $display("[TB] FAIL rnd_idle: got %b expected 0", {fAck, fErr, dAck, dErr, busy, mSyn});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_write();
    test_timeout();
    test_idle_ack();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
